// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: interrupt source, configuration and request signals between
// the interrupt controller and the coprocessor side.
interface irq_ctrl_if;
    logic [7:0] irq_raw;
    logic       cfg_we;
    logic [7:0] cfg_enable;
    logic [7:0] cfg_edge;
    logic       sw_clr_we;
    logic [7:0] sw_clr_mask;
    logic       int_ack;
    logic [7:0] hardware_interrupt;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic [7:0] enable;
    logic [7:0] edge_mode;
    logic       irq_any;
    logic [2:0] top_num;

    modport master (
        output irq_raw, cfg_we, cfg_enable, cfg_edge, sw_clr_we, sw_clr_mask, int_ack,
        input  hardware_interrupt, pending, overrun, enable, edge_mode, irq_any, top_num
    );

    modport slave (
        input  irq_raw, cfg_we, cfg_enable, cfg_edge, sw_clr_we, sw_clr_mask, int_ack,
        output hardware_interrupt, pending, overrun, enable, edge_mode, irq_any, top_num
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source interrupt controller with input synchronizers, per-source
// edge/level modes, sticky overrun flags and fixed-priority request encoding.
module irq_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RST_ENABLE  = 8'h00,
    parameter logic [7:0] RST_EDGE    = 8'hff
) (
    input logic       clk,
    input logic       clr,
    irq_ctrl_if.slave bus
);
    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0] r_prev, r_pending, r_overrun, r_enable, r_edge;
    logic [7:0] w_sync, w_rise, w_set, w_sw, w_ack, w_cut, w_chg, w_hw, w_pend_nx, w_ov_nx;
    logic [2:0] w_top;
    logic       w_any;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_hw   = r_pending & r_enable;
    assign w_any  = |w_hw;
    assign w_set  = w_rise & r_enable & r_edge;
    assign w_sw   = bus.sw_clr_we ? bus.sw_clr_mask : 8'h00;
    assign w_ack  = (bus.int_ack && w_any) ? 8'h01 << w_top : 8'h00;
    assign w_cut  = w_sw | w_ack;
    assign w_chg  = bus.cfg_we ? (bus.cfg_edge ^ r_edge) : 8'h00;

    always_comb begin
        w_top = 3'd0;
        for (int i = 0; i < 8; i++) w_top = w_hw[i] ? 3'(i) : w_top;
    end

    // Edge bits latch until cleared (a new rise beats any clear); level bits follow the input.
    assign w_pend_nx = ((r_edge & (w_set | (r_pending & ~w_cut))) | (~r_edge & w_sync & r_enable)) & ~w_chg;
    assign w_ov_nx   = ((w_set & r_pending & ~w_cut) | (r_overrun & ~w_sw)) & ~w_chg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync    <= '0;
            r_prev    <= 8'h00;
            r_pending <= 8'h00;
            r_overrun <= 8'h00;
            r_enable  <= RST_ENABLE;
            r_edge    <= RST_EDGE;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.irq_raw};
            r_prev    <= w_sync;
            r_pending <= w_pend_nx;
            r_overrun <= w_ov_nx;
            if (bus.cfg_we) begin
                r_enable <= bus.cfg_enable;
                r_edge   <= bus.cfg_edge;
            end
        end
    end

    assign bus.hardware_interrupt = w_hw;
    assign bus.pending            = r_pending;
    assign bus.overrun            = r_overrun;
    assign bus.enable             = r_enable;
    assign bus.edge_mode          = r_edge;
    assign bus.irq_any            = w_any;
    assign bus.top_num            = w_top;
endmodule
